// File: rtl/lcd_scanout.sv
// lcd_scanout: reads the 64-line x 160-nibble Z88 frame buffer out of VRAM
// and presents it as a 640x480@60 raster. Each Z88 line is shown on four
// consecutive VGA lines, centred in a 256-line window. Timing advances on
// pce; the outputs hsync/vsync/de/pix are registered together so they share
// one pce of latency relative to the counters.
module lcd_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_TOP    = 112
) (
  input  logic        mck,
  input  logic        rin,
  input  logic        pce,
  input  logic        lcdon,
  output logic [13:0] vram_a,
  input  logic [3:0]  vram_di,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        pix,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int V_WIN   = 256;

  // 10-bit copies of the geometry so every compare is width-matched.
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  // Last fetch slot of a line; it prefetches nibble 0 of the next line.
  localparam logic [9:0] H_FETCH_LAST = 10'(H_TOTAL - 3);
  localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START     = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END       = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END       = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] WIN_START    = 10'(V_TOP);
  localparam logic [9:0] WIN_END      = 10'(V_TOP + V_WIN);

  logic [9:0]  hcnt;
  logic [9:0]  vcnt;
  logic [3:0]  shreg;

  logic        h_wrap;
  logic        v_wrap;
  logic [9:0]  vcnt_succ;
  logic        de_next;
  logic        hsync_next;
  logic        vsync_next;
  logic        inwin;
  logic        pix_next;
  logic [13:0] fetch_addr;

  // Z88 line shown on VGA line v; wraps harmlessly outside the window.
  function automatic logic [5:0] zline_of(input logic [9:0] v);
    return 6'((v - WIN_START) >> 2);
  endfunction

  // Decode the counters into next-output values and the next fetch address.
  // NOTE: each always_comb output is assigned a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    h_wrap     = (hcnt == H_LAST);
    v_wrap     = (vcnt == V_LAST);
    vcnt_succ  = v_wrap ? 10'd0 : vcnt + 10'd1;
    de_next    = (hcnt < H_ACT) && (vcnt < V_ACT);
    hsync_next = !((hcnt >= HS_START) && (hcnt < HS_END));
    vsync_next = !((vcnt >= VS_START) && (vcnt < VS_END));
    inwin      = lcdon && (vcnt >= WIN_START) && (vcnt < WIN_END);
    // 3 - hcnt[1:0] is the bitwise inverse for a 2-bit index.
    pix_next   = inwin && de_next && shreg[~hcnt[1:0]];
    fetch_addr = vram_a;
    if ((hcnt[1:0] == 2'b01) && (hcnt < H_FETCH_LAST)) begin
      fetch_addr = {zline_of(vcnt), hcnt[9:2] + 8'd1};
    end else if (hcnt == H_FETCH_LAST) begin
      fetch_addr = {zline_of(vcnt_succ), 8'd0};
    end
  end

  // Horizontal and vertical raster counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // in the design updates from the same pre-edge values.
  always_ff @(posedge mck) begin
    if (rin) begin
      hcnt <= 10'd0;
      vcnt <= 10'd0;
    end else if (pce) begin
      hcnt <= h_wrap ? 10'd0 : hcnt + 10'd1;
      if (h_wrap) begin
        vcnt <= vcnt_succ;
      end
    end
  end

  // VRAM address generation and nibble capture; runs regardless of lcdon.
  always_ff @(posedge mck) begin
    if (rin) begin
      vram_a <= 14'd0;
      shreg  <= 4'd0;
    end else if (pce) begin
      vram_a <= fetch_addr;
      if (hcnt[1:0] == 2'b11) begin
        shreg <= vram_di;
      end
    end
  end

  // Registered video outputs, all updated on the same pce edge.
  always_ff @(posedge mck) begin
    if (rin) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
      pix   <= 1'b0;
    end else if (pce) begin
      hsync <= hsync_next;
      vsync <= vsync_next;
      de    <= de_next;
      pix   <= pix_next;
    end
  end

  // One-mck pulse when both counters wrap; cleared on every other mck.
  always_ff @(posedge mck) begin
    if (rin) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pce && h_wrap && v_wrap;
    end
  end

endmodule
